// File: rtl/gx_x4_reset_ctrl.sv
// Reset sequencer for a bonded x4 transceiver: one TX sequencer shared by all lanes
// and four independent RX sequencers, driven from synchronized status inputs.
module gx_x4_reset_ctrl #(
    parameter int T_ANALOG = 70,
    parameter int T_LTD    = 4000,
    parameter int T_TXDIG  = 16
) (
    input  logic       reconfig_clk,
    input  logic       reconfig_reset_n,
    input  logic       tx_pll_locked,
    input  logic [3:0] tx_cal_busy,
    input  logic [3:0] rx_cal_busy,
    input  logic [3:0] rx_is_lockedtodata,
    input  logic       tx_rst_req,
    input  logic [3:0] rx_rst_req,
    output logic [3:0] tx_analogreset,
    output logic [3:0] tx_digitalreset,
    output logic [3:0] rx_analogreset,
    output logic [3:0] rx_digitalreset,
    output logic [3:0] tx_ready,
    output logic [3:0] rx_ready
);

    localparam logic [15:0] ANA_LAST = 16'(T_ANALOG - 1);
    localparam logic [15:0] LTD_LAST = 16'(T_LTD - 1);
    localparam logic [15:0] DIG_LAST = 16'(T_TXDIG - 1);

    typedef enum logic [2:0] {
        TX_ANA, TX_WAIT_PLL, TX_WAIT_CAL, TX_DIG, TX_RDY
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_ANA, RX_WAIT_CAL, RX_WAIT_LTD, RX_RDY
    } rx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic       pll_s1, pll_s2;
    logic [3:0] txcal_s1, txcal_s2;
    logic [3:0] rxcal_s1, rxcal_s2;
    logic [3:0] ltd_s1, ltd_s2;

    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            pll_s1   <= 1'b0;
            pll_s2   <= 1'b0;
            txcal_s1 <= 4'h0;
            txcal_s2 <= 4'h0;
            rxcal_s1 <= 4'h0;
            rxcal_s2 <= 4'h0;
            ltd_s1   <= 4'h0;
            ltd_s2   <= 4'h0;
        end else begin
            pll_s1   <= tx_pll_locked;
            pll_s2   <= pll_s1;
            txcal_s1 <= tx_cal_busy;
            txcal_s2 <= txcal_s1;
            rxcal_s1 <= rx_cal_busy;
            rxcal_s2 <= rxcal_s1;
            ltd_s1   <= rx_is_lockedtodata;
            ltd_s2   <= ltd_s1;
        end
    end

    tx_state_t   tx_state, tx_state_nx;
    logic [15:0] tx_cnt, tx_cnt_nx;
    logic        tx_ana_q, tx_dig_q, tx_rdy_q;

    // Lock loss outranks calibration activity; a restart request outranks both.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        if (tx_rst_req) begin
            tx_state_nx = TX_ANA;
            tx_cnt_nx   = 16'd0;
        end else begin
            case (tx_state)
                TX_ANA: begin
                    if (tx_cnt >= ANA_LAST) begin
                        tx_state_nx = TX_WAIT_PLL;
                        tx_cnt_nx   = 16'd0;
                    end else begin
                        tx_cnt_nx = sat_inc(tx_cnt);
                    end
                end
                TX_WAIT_PLL: begin
                    if (pll_s2) begin
                        tx_state_nx = TX_WAIT_CAL;
                        tx_cnt_nx   = 16'd0;
                    end
                end
                TX_WAIT_CAL: begin
                    if (!pll_s2) begin
                        tx_state_nx = TX_WAIT_PLL;
                    end else if (txcal_s2 == 4'h0) begin
                        tx_state_nx = TX_DIG;
                        tx_cnt_nx   = 16'd0;
                    end
                end
                TX_DIG: begin
                    if (!pll_s2) begin
                        tx_state_nx = TX_WAIT_PLL;
                        tx_cnt_nx   = 16'd0;
                    end else if (|txcal_s2) begin
                        tx_state_nx = TX_WAIT_CAL;
                        tx_cnt_nx   = 16'd0;
                    end else if (tx_cnt >= DIG_LAST) begin
                        tx_state_nx = TX_RDY;
                        tx_cnt_nx   = 16'd0;
                    end else begin
                        tx_cnt_nx = sat_inc(tx_cnt);
                    end
                end
                TX_RDY: begin
                    if (!pll_s2) begin
                        tx_state_nx = TX_WAIT_PLL;
                    end else if (|txcal_s2) begin
                        tx_state_nx = TX_WAIT_CAL;
                    end
                end
                default: begin
                    tx_state_nx = TX_ANA;
                    tx_cnt_nx   = 16'd0;
                end
            endcase
        end
    end

    // Output flops are loaded from the next state so they track the state register exactly.
    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            tx_state <= TX_ANA;
            tx_cnt   <= 16'd0;
            tx_ana_q <= 1'b1;
            tx_dig_q <= 1'b1;
            tx_rdy_q <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_ana_q <= (tx_state_nx == TX_ANA);
            tx_dig_q <= (tx_state_nx != TX_RDY);
            tx_rdy_q <= (tx_state_nx == TX_RDY);
        end
    end

    assign tx_analogreset  = {4{tx_ana_q}};
    assign tx_digitalreset = {4{tx_dig_q}};
    assign tx_ready        = {4{tx_rdy_q}};

    for (genvar i = 0; i < 4; i++) begin : g_rx
        rx_state_t   rx_state, rx_state_nx;
        logic [15:0] rx_cnt, rx_cnt_nx;
        logic        ana_q, dig_q, rdy_q;

        always_comb begin
            rx_state_nx = rx_state;
            rx_cnt_nx   = rx_cnt;
            if (rx_rst_req[i]) begin
                rx_state_nx = RX_ANA;
                rx_cnt_nx   = 16'd0;
            end else begin
                case (rx_state)
                    RX_ANA: begin
                        if (rx_cnt >= ANA_LAST) begin
                            rx_state_nx = RX_WAIT_CAL;
                            rx_cnt_nx   = 16'd0;
                        end else begin
                            rx_cnt_nx = sat_inc(rx_cnt);
                        end
                    end
                    RX_WAIT_CAL: begin
                        if (!rxcal_s2[i]) begin
                            rx_state_nx = RX_WAIT_LTD;
                            rx_cnt_nx   = 16'd0;
                        end
                    end
                    RX_WAIT_LTD: begin
                        if (!ltd_s2[i]) begin
                            rx_cnt_nx = 16'd0;
                        end else if (rx_cnt >= LTD_LAST) begin
                            rx_state_nx = RX_RDY;
                            rx_cnt_nx   = 16'd0;
                        end else begin
                            rx_cnt_nx = sat_inc(rx_cnt);
                        end
                    end
                    RX_RDY: begin
                        if (!ltd_s2[i]) begin
                            rx_state_nx = RX_WAIT_LTD;
                            rx_cnt_nx   = 16'd0;
                        end else if (rxcal_s2[i]) begin
                            rx_state_nx = RX_WAIT_CAL;
                            rx_cnt_nx   = 16'd0;
                        end
                    end
                    default: begin
                        rx_state_nx = RX_ANA;
                        rx_cnt_nx   = 16'd0;
                    end
                endcase
            end
        end

        always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
            if (!reconfig_reset_n) begin
                rx_state <= RX_ANA;
                rx_cnt   <= 16'd0;
                ana_q    <= 1'b1;
                dig_q    <= 1'b1;
                rdy_q    <= 1'b0;
            end else begin
                rx_state <= rx_state_nx;
                rx_cnt   <= rx_cnt_nx;
                ana_q    <= (rx_state_nx == RX_ANA);
                dig_q    <= (rx_state_nx != RX_RDY);
                rdy_q    <= (rx_state_nx == RX_RDY);
            end
        end

        assign rx_analogreset[i]  = ana_q;
        assign rx_digitalreset[i] = dig_q;
        assign rx_ready[i]        = rdy_q;
    end

endmodule

// File: tb/tb_gx_x4_reset_ctrl.sv
// Self-checking bench for gx_x4_reset_ctrl: directed sequences plus random status
// perturbation, compared every cycle against a phase/age reference model.
module tb_gx_x4_reset_ctrl;

    localparam int T_ANALOG = 8;
    localparam int T_LTD    = 16;
    localparam int T_TXDIG  = 4;

    logic       reconfig_clk;
    logic       reconfig_reset_n;
    logic       tx_pll_locked;
    logic [3:0] tx_cal_busy, rx_cal_busy, rx_is_lockedtodata;
    logic       tx_rst_req;
    logic [3:0] rx_rst_req;
    logic [3:0] tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
    logic [3:0] tx_ready, rx_ready;

    gx_x4_reset_ctrl #(
        .T_ANALOG(T_ANALOG), .T_LTD(T_LTD), .T_TXDIG(T_TXDIG)
    ) dut (
        .reconfig_clk      (reconfig_clk),
        .reconfig_reset_n  (reconfig_reset_n),
        .tx_pll_locked     (tx_pll_locked),
        .tx_cal_busy       (tx_cal_busy),
        .rx_cal_busy       (rx_cal_busy),
        .rx_is_lockedtodata(rx_is_lockedtodata),
        .tx_rst_req        (tx_rst_req),
        .rx_rst_req        (rx_rst_req),
        .tx_analogreset    (tx_analogreset),
        .tx_digitalreset   (tx_digitalreset),
        .rx_analogreset    (rx_analogreset),
        .rx_digitalreset   (rx_digitalreset),
        .tx_ready          (tx_ready),
        .rx_ready          (rx_ready)
    );

    initial reconfig_clk = 1'b0;
    always #5 reconfig_clk = ~reconfig_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: phase per sequencer plus cycles spent in that phase.
    typedef struct packed {
        logic       pll;
        logic [3:0] txcal;
        logic [3:0] rxcal;
        logic [3:0] ltd;
    } view_t;

    typedef enum int {M_ANA, M_PLL, M_CAL, M_DIG, M_RDY} tx_phase_t;
    typedef enum int {R_ANA, R_CAL, R_LTD, R_RDY} rx_phase_t;

    view_t     hist[$];
    tx_phase_t tx_ph;
    int        tx_age;
    rx_phase_t rx_ph [4];
    int        rx_age[4];
    int        rx_run[4];

    task automatic model_reset();
        view_t z;
        z = '0;
        tx_ph  = M_ANA;
        tx_age = 0;
        for (int i = 0; i < 4; i++) begin
            rx_ph[i]  = R_ANA;
            rx_age[i] = 0;
            rx_run[i] = 0;
        end
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
    endtask

    task automatic model_step();
        view_t     v;
        tx_phase_t tn;
        rx_phase_t rn;
        if (!reconfig_reset_n) begin
            model_reset();
            return;
        end
        v = hist.pop_front();
        hist.push_back({tx_pll_locked, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata});

        tx_age++;
        tn = tx_ph;
        if (tx_rst_req) tn = M_ANA;
        else case (tx_ph)
            M_ANA: if (tx_age >= T_ANALOG) tn = M_PLL;
            M_PLL: if (v.pll) tn = M_CAL;
            M_CAL: if (!v.pll) tn = M_PLL; else if (v.txcal == 4'h0) tn = M_DIG;
            M_DIG: if (!v.pll) tn = M_PLL; else if (v.txcal != 4'h0) tn = M_CAL;
                   else if (tx_age >= T_TXDIG) tn = M_RDY;
            M_RDY: if (!v.pll) tn = M_PLL; else if (v.txcal != 4'h0) tn = M_CAL;
            default: tn = M_ANA;
        endcase
        if (tx_rst_req || tn != tx_ph) tx_age = 0;
        tx_ph = tn;

        for (int i = 0; i < 4; i++) begin
            rx_age[i]++;
            rn = rx_ph[i];
            if (rx_rst_req[i]) rn = R_ANA;
            else case (rx_ph[i])
                R_ANA: if (rx_age[i] >= T_ANALOG) rn = R_CAL;
                R_CAL: if (!v.rxcal[i]) rn = R_LTD;
                R_LTD: begin
                    rx_run[i] = v.ltd[i] ? rx_run[i] + 1 : 0;
                    if (rx_run[i] >= T_LTD) rn = R_RDY;
                end
                R_RDY: if (!v.ltd[i]) rn = R_LTD; else if (v.rxcal[i]) rn = R_CAL;
                default: rn = R_ANA;
            endcase
            if (rx_rst_req[i] || rn != rx_ph[i]) begin
                rx_age[i] = 0;
                rx_run[i] = 0;
            end
            rx_ph[i] = rn;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] ea, ed, er;
        check("tx_analogreset",  tx_analogreset,  (tx_ph == M_ANA) ? 4'hF : 4'h0);
        check("tx_digitalreset", tx_digitalreset, (tx_ph != M_RDY) ? 4'hF : 4'h0);
        check("tx_ready",        tx_ready,        (tx_ph == M_RDY) ? 4'hF : 4'h0);
        for (int i = 0; i < 4; i++) begin
            ea[i] = (rx_ph[i] == R_ANA);
            ed[i] = (rx_ph[i] != R_RDY);
            er[i] = (rx_ph[i] == R_RDY);
        end
        check("rx_analogreset",  rx_analogreset,  ea);
        check("rx_digitalreset", rx_digitalreset, ed);
        check("rx_ready",        rx_ready,        er);
    endtask

    task automatic tick();
        @(posedge reconfig_clk);
        model_step();
        if (reconfig_reset_n) cyc++; else cyc = 0;
        @(negedge reconfig_clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic pll, input logic [3:0] txcal,
                                 input logic [3:0] rxcal, input logic [3:0] ltd);
        tx_pll_locked      = pll;
        tx_cal_busy        = txcal;
        rx_cal_busy        = rxcal;
        rx_is_lockedtodata = ltd;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ta_fall, tx_rise;
        int rx_rise[4];
        int ana_cnt;
        int r, idx;
        bit found;

        model_reset();
        reconfig_reset_n = 1'b0;
        tx_rst_req = 1'b0;
        rx_rst_req = 4'h0;
        applyStimulus(1'b1, 4'h0, 4'h0, 4'hF);
        repeat (3) tick();
        check("reset_tx_ana", tx_analogreset, 4'hF);
        check("reset_rx_dig", rx_digitalreset, 4'hF);
        check("reset_tx_rdy", tx_ready, 4'h0);
        check("reset_rx_rdy", rx_ready, 4'h0);

        // Bring-up, with a one-cycle lock glitch on RX lane 2 mid-count.
        $display("[TB] bring-up sequence");
        reconfig_reset_n = 1'b1;
        ta_fall = -1;
        tx_rise = -1;
        for (int i = 0; i < 4; i++) rx_rise[i] = -1;
        for (int n = 0; n < 45; n++) begin
            tick();
            if (cyc == 16) rx_is_lockedtodata[2] = 1'b0;
            if (cyc == 17) rx_is_lockedtodata[2] = 1'b1;
            if (ta_fall < 0 && tx_analogreset == 4'h0) ta_fall = cyc;
            if (tx_rise < 0 && tx_ready == 4'hF) tx_rise = cyc;
            for (int i = 0; i < 4; i++)
                if (rx_rise[i] < 0 && rx_ready[i]) rx_rise[i] = cyc;
        end
        check("tx_ana_fall_cycle", 4'(ta_fall), 4'(T_ANALOG));
        check("tx_ready_cycle",    4'(tx_rise), 4'(14));
        check("rx0_ready_cycle",   5'(rx_rise[0]) == 5'd25, 4'h1);
        check("rx1_ready_cycle",   5'(rx_rise[1]) == 5'd25, 4'h1);
        check("rx3_ready_cycle",   5'(rx_rise[3]) == 5'd25, 4'h1);
        check("rx2_ready_delayed", 6'(rx_rise[2]) == 6'd35, 4'h1);

        // Lock loss on RX lane 1 while ready.
        $display("[TB] rx lane 1 lock loss");
        rx_is_lockedtodata[1] = 1'b0;
        tick();
        tick();
        check("rx1_still_ready", {3'b0, rx_ready[1]}, 4'h1);
        tick();
        check("rx1_ready_drop", {3'b0, rx_ready[1]}, 4'h0);
        check("rx1_dig_set",    {3'b0, rx_digitalreset[1]}, 4'h1);
        check("rx1_ana_clear",  {3'b0, rx_analogreset[1]}, 4'h0);
        check("rx_others_ok",   rx_ready & 4'b1101, 4'b1101);
        rx_is_lockedtodata[1] = 1'b1;
        repeat (25) tick();
        check("rx1_relock", rx_ready, 4'hF);

        // TX PLL lock loss while ready.
        $display("[TB] tx pll lock loss");
        tx_pll_locked = 1'b0;
        tick();
        tick();
        check("tx_still_ready", tx_ready, 4'hF);
        tick();
        check("tx_ready_drop", tx_ready, 4'h0);
        check("tx_dig_set",    tx_digitalreset, 4'hF);
        check("tx_ana_clear",  tx_analogreset, 4'h0);
        tx_pll_locked = 1'b1;
        repeat (12) tick();
        check("tx_relock", tx_ready, 4'hF);
        check("rx_unaffected_by_tx", rx_ready, 4'hF);

        // RX restart coinciding with lock loss on lane 3.
        $display("[TB] rx lane 3 restart during lock loss");
        rx_is_lockedtodata[3] = 1'b0;
        tick();
        tick();
        rx_rst_req[3] = 1'b1;
        tick();
        rx_rst_req[3] = 1'b0;
        check("rx3_ana_entered", {3'b0, rx_analogreset[3]}, 4'h1);
        ana_cnt = 1;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (rx_analogreset[3]) ana_cnt++;
        end
        check("rx3_ana_length", 4'(ana_cnt), 4'(T_ANALOG));
        check("rx012_kept", rx_ready, 4'b0111);
        rx_is_lockedtodata[3] = 1'b1;
        repeat (30) tick();
        check("rx3_recovered", rx_ready, 4'hF);

        // Random perturbation of status inputs and restart requests.
        $display("[TB] random phase");
        for (int n = 0; n < 600; n++) begin
            r   = $urandom_range(0, 99);
            idx = $urandom_range(0, 3);
            if (r < 3)       tx_pll_locked = ~tx_pll_locked;
            else if (r < 7)  rx_cal_busy[idx] = ~rx_cal_busy[idx];
            else if (r < 13) rx_is_lockedtodata[idx] = ~rx_is_lockedtodata[idx];
            else if (r < 15) tx_cal_busy[idx] = ~tx_cal_busy[idx];
            else if (r < 17) tx_rst_req = 1'b1;
            else if (r < 20) rx_rst_req[idx] = 1'b1;
            else if (r < 24) applyStimulus(1'b1, 4'h0, 4'h0, 4'hF);
            tick();
            tx_rst_req = 1'b0;
            rx_rst_req = 4'h0;
        end

        // Asynchronous reset while TX is holding digital reset after calibration.
        $display("[TB] async reset during tx digital hold");
        reconfig_reset_n = 1'b0;
        applyStimulus(1'b1, 4'h0, 4'h0, 4'hF);
        repeat (2) tick();
        reconfig_reset_n = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            tick();
            if (tx_ph == M_DIG) found = 1'b1;
        end
        check("find_tx_dig", {3'b0, found}, 4'h1);
        reconfig_reset_n = 1'b0;
        #1;
        check("async_tx_ana", tx_analogreset,  4'hF);
        check("async_tx_dig", tx_digitalreset, 4'hF);
        check("async_tx_rdy", tx_ready,        4'h0);
        check("async_rx_ana", rx_analogreset,  4'hF);
        check("async_rx_dig", rx_digitalreset, 4'hF);
        check("async_rx_rdy", rx_ready,        4'h0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gx_x4_reset_ctrl.md
GX_X4_RESET_CTRL -- requirements
Module: gx_x4_reset_ctrl

Interface
REQ-001 SHALL have parameter T_ANALOG, default 70: cycles analog reset is held, range 2..65535.
REQ-002 SHALL have parameter T_LTD, default 4000: cycles rx_is_lockedtodata must be continuously high before digital reset release, range 2..65535.
REQ-003 SHALL have parameter T_TXDIG, default 16: cycles tx_digitalreset is held after TX calibration completes, range 1..255.
REQ-004 SHALL have port reconfig_clk, in, 1: sole clock; all logic is on its rising edge.
REQ-005 SHALL have port reconfig_reset_n, in, 1: asynchronous active-low reset.
REQ-006 SHALL have port tx_pll_locked, in, 1: bonded TX PLL lock (asynchronous).
REQ-007 SHALL have ports tx_cal_busy / rx_cal_busy, in, 4 each: per-channel calibration busy (asynchronous).
REQ-008 SHALL have port rx_is_lockedtodata, in, 4: per-channel CDR lock (asynchronous).
REQ-009 SHALL have port tx_rst_req, in, 1: synchronous one-cycle TX restart request.
REQ-010 SHALL have port rx_rst_req, in, 4: synchronous one-cycle per-channel RX restart request.
REQ-011 SHALL have ports tx_analogreset / tx_digitalreset, out, 4 each: TX resets, active-high, identical on all bits (bonded).
REQ-012 SHALL have ports rx_analogreset / rx_digitalreset, out, 4 each: per-channel RX resets, active-high.
REQ-013 SHALL have ports tx_ready / rx_ready, out, 4 each: channel operational.

Function
REQ-014 SHALL pass tx_pll_locked, tx_cal_busy, rx_cal_busy and rx_is_lockedtodata through two-flop synchronizers; all timings below are counted from the synchronized values (2-cycle input latency).
REQ-015 SHALL implement one TX FSM with states TX_ANA, TX_WAIT_PLL, TX_WAIT_CAL, TX_DIG, TX_RDY.
REQ-016 TX_ANA: analog=1, digital=1; leave to TX_WAIT_PLL after exactly T_ANALOG cycles.
REQ-017 TX_WAIT_PLL: analog=0, digital=1; go to TX_WAIT_CAL when the synchronized tx_pll_locked=1.
REQ-018 TX_WAIT_CAL: digital=1; go to TX_DIG when all 4 synchronized tx_cal_busy bits=0.
REQ-019 TX_DIG: digital=1 for T_TXDIG cycles, then TX_RDY: digital=0, tx_ready=4'hF.
REQ-020 In TX_WAIT_CAL, TX_DIG or TX_RDY, a synchronized tx_pll_locked=0 SHALL return the FSM to TX_WAIT_PLL (digital=1, tx_ready=0 the next cycle); any tx_cal_busy=1 in TX_DIG or TX_RDY SHALL return it to TX_WAIT_CAL.
REQ-021 tx_rst_req=1 in any state SHALL enter TX_ANA the next cycle and restart the counter at 0.
REQ-022 SHALL implement four independent RX FSMs (channel i), states RX_ANA, RX_WAIT_CAL, RX_WAIT_LTD, RX_RDY.
REQ-023 RX_ANA: analog[i]=1, digital[i]=1 for exactly T_ANALOG cycles, then RX_WAIT_CAL: analog[i]=0.
REQ-024 RX_WAIT_CAL: go to RX_WAIT_LTD when synchronized rx_cal_busy[i]=0.
REQ-025 RX_WAIT_LTD: the counter increments while lockedtodata[i]=1 and clears to 0 on any 0; on reaching T_LTD, go to RX_RDY: digital[i]=0, rx_ready[i]=1.
REQ-026 RX_RDY: lockedtodata[i]=0 SHALL go to RX_WAIT_LTD (digital[i]=1, ready[i]=0, counter=0) without analog reset; rx_cal_busy[i]=1 SHALL go to RX_WAIT_CAL.
REQ-027 rx_rst_req[i]=1 SHALL force RX_ANA for channel i only, with priority over every other transition, including when it coincides with a lock loss.
REQ-028 Counters SHALL be 16 bits and saturate, never wrap.
REQ-029 All outputs SHALL be registered; there is no combinational path from input to output.

Reset
REQ-030 When reconfig_reset_n=0, asynchronously: all FSMs are in their _ANA state, counters and synchronizers are 0, all analog/digital resets are 4'hF, and tx_ready/rx_ready are 4'h0.
REQ-031 After reset deassertion, counting SHALL begin on the first rising edge; reset assertion mid-sequence SHALL abort the sequence immediately.

Verification (T_ANALOG=8, T_LTD=16, T_TXDIG=4)
REQ-032 Release reset, hold PLL locked, cal_busy=0, LTD=1 -> tx_analogreset falls after 8 cycles; tx_ready=4'hF after approximately 8+3+4 cycles; rx_ready=4'hF at approximately 8+3+16 cycles.
REQ-033 In RX_WAIT_LTD, toggle rx_is_lockedtodata[2] low for 1 cycle at count 10 -> rx_ready[2] is delayed by 16 cycles from the relock; other channels are unaffected.
REQ-034 In RX_RDY, drop rx_is_lockedtodata[1] -> rx_digitalreset[1]=1 and rx_ready[1]=0 after 3 cycles; rx_analogreset[1] stays 0.
REQ-035 In TX_RDY, drop tx_pll_locked -> tx_ready=0 and tx_digitalreset=4'hF after 3 cycles; the restore follows REQ-017..019.
REQ-036 Assert rx_rst_req[3] in the same cycle that lock is lost on channel 3 -> channel 3 enters RX_ANA (analogreset[3]=1 for 8 cycles); channels 0..2 keep rx_ready=1.
REQ-037 Assert reconfig_reset_n=0 mid-TX_DIG -> all outputs reach their reset values without waiting for a clock edge.
